// File: rtl/llc_input_queues_pkg.sv
// llc_input_queues_pkg: shared LLC cache types and address-split constants.
package llc_input_queues_pkg;
  localparam int LINE_ADDR_BITS = 16;
  localparam int LLC_SET_BITS = 5;
  localparam int LLC_TAG_BITS = LINE_ADDR_BITS - LLC_SET_BITS;
  typedef logic [LINE_ADDR_BITS-1:0] line_addr_t;
  typedef logic [LLC_SET_BITS-1:0] llc_set_t;
  typedef logic [LLC_TAG_BITS-1:0] llc_tag_t;
  typedef struct packed {
    logic [2:0] coh_msg;
    logic [1:0] hprot;
    line_addr_t addr;
    logic [3:0] req_id;
  } llc_req_in_t;
  typedef struct packed {
    logic [2:0]  coh_msg;
    line_addr_t  addr;
    logic [31:0] line;
    logic [3:0]  req_id;
  } llc_rsp_in_t;
  typedef struct packed {
    logic [2:0]  coh_msg;
    line_addr_t  addr;
    logic [31:0] word;
    logic [3:0]  req_id;
  } llc_dma_req_in_t;
  function automatic llc_set_t addr_set(input line_addr_t a);
    return a[LLC_SET_BITS-1:0];
  endfunction
  function automatic llc_tag_t addr_tag(input line_addr_t a);
    return a[LINE_ADDR_BITS-1:LLC_SET_BITS];
  endfunction
endpackage

// File: rtl/llc_input_queues_fifo.sv
// llc_input_fifo: DEPTH-entry circular FIFO with registered ready and
// unregistered head mux; flags a pop attempted while empty.
module llc_input_fifo #(
  parameter type T = logic,
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_valid,
  output logic o_ready,
  input  T     i_data,
  input  logic i_get,
  output logic o_valid,
  output T     o_head,
  output logic o_underflow
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  T r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  assign o_ready = r_count != CW'(DEPTH);
  assign o_valid = r_count != '0;
  assign o_head = r_mem[r_rd_ptr];
  assign w_push = i_valid && o_ready;
  assign w_pop = i_get && o_valid;
  assign o_underflow = i_get && !o_valid;
  always_ff @(posedge clk)
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr == PW'(DEPTH-1) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop) r_rd_ptr <= r_rd_ptr == PW'(DEPTH-1) ? '0 : r_rd_ptr + 1'b1;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  always_ff @(posedge clk)
    if (rst && w_push) r_mem[r_wr_ptr] <= i_data;
endmodule

// File: rtl/llc_input_queues.sv
// llc_input_queues: LLC ingress buffering for request, response and DMA
// channels, plus a 1-entry flush request and a stalled-request holding register.
module llc_input_queues
  import llc_input_queues_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            llc_req_in_valid,
  output logic            llc_req_in_ready,
  input  llc_req_in_t     llc_req_in_data,
  input  logic            llc_rsp_in_valid,
  output logic            llc_rsp_in_ready,
  input  llc_rsp_in_t     llc_rsp_in_data,
  input  logic            llc_dma_req_in_valid,
  output logic            llc_dma_req_in_ready,
  input  llc_dma_req_in_t llc_dma_req_in_data,
  input  logic            llc_rst_tb_valid,
  output logic            llc_rst_tb_ready,
  input  logic            llc_rst_tb_data,
  input  logic            get_req,
  input  logic            get_rsp,
  input  logic            get_dma_req,
  input  logic            get_rst_tb,
  output logic            llc_req_in_valid_int,
  output logic            llc_rsp_in_valid_int,
  output logic            llc_dma_req_in_valid_int,
  output logic            llc_rst_tb_valid_int,
  output llc_req_in_t     req_in_head,
  output llc_rsp_in_t     rsp_in_head,
  output llc_dma_req_in_t dma_req_in_head,
  output logic            rst_tb_head,
  input  logic            set_req_in_stalled,
  input  logic            clr_req_in_stalled_valid,
  output logic            req_in_stalled_valid,
  output llc_req_in_t     req_in_stalled,
  output llc_set_t        req_in_stalled_set,
  output llc_tag_t        req_in_stalled_tag,
  output logic            underflow_err
);
  logic w_uf_req, w_uf_rsp, w_uf_dma;
  logic r_rst_tb_valid, r_rst_tb_data, r_stalled_valid, r_underflow;
  llc_req_in_t r_stalled;
  llc_input_fifo #(.T(llc_req_in_t), .DEPTH(DEPTH)) u_req (
    .clk(clk), .rst(rst), .i_valid(llc_req_in_valid), .o_ready(llc_req_in_ready),
    .i_data(llc_req_in_data), .i_get(get_req), .o_valid(llc_req_in_valid_int),
    .o_head(req_in_head), .o_underflow(w_uf_req));
  llc_input_fifo #(.T(llc_rsp_in_t), .DEPTH(DEPTH)) u_rsp (
    .clk(clk), .rst(rst), .i_valid(llc_rsp_in_valid), .o_ready(llc_rsp_in_ready),
    .i_data(llc_rsp_in_data), .i_get(get_rsp), .o_valid(llc_rsp_in_valid_int),
    .o_head(rsp_in_head), .o_underflow(w_uf_rsp));
  llc_input_fifo #(.T(llc_dma_req_in_t), .DEPTH(DEPTH)) u_dma (
    .clk(clk), .rst(rst), .i_valid(llc_dma_req_in_valid), .o_ready(llc_dma_req_in_ready),
    .i_data(llc_dma_req_in_data), .i_get(get_dma_req), .o_valid(llc_dma_req_in_valid_int),
    .o_head(dma_req_in_head), .o_underflow(w_uf_dma));
  assign llc_rst_tb_ready = !r_rst_tb_valid;
  assign llc_rst_tb_valid_int = r_rst_tb_valid;
  assign rst_tb_head = r_rst_tb_data;
  assign req_in_stalled_valid = r_stalled_valid;
  assign req_in_stalled = r_stalled;
  assign req_in_stalled_set = addr_set(r_stalled.addr);
  assign req_in_stalled_tag = addr_tag(r_stalled.addr);
  assign underflow_err = r_underflow;
  // data registers are only loaded out of reset and never cleared
  always_ff @(posedge clk)
    if (!rst) begin
      r_rst_tb_valid <= 1'b0;
      r_stalled_valid <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (get_rst_tb) r_rst_tb_valid <= 1'b0;
      else if (llc_rst_tb_valid && !r_rst_tb_valid) begin
        r_rst_tb_valid <= 1'b1;
        r_rst_tb_data <= llc_rst_tb_data;
      end
      if (set_req_in_stalled) begin
        r_stalled_valid <= 1'b1;
        r_stalled <= req_in_head;
      end else if (clr_req_in_stalled_valid) r_stalled_valid <= 1'b0;
      r_underflow <= r_underflow | w_uf_req | w_uf_rsp | w_uf_dma;
    end
endmodule

// File: tb/tb_llc_input_queues.sv
// tb_llc_input_queues: randomized stimulus against a queue-based model;
// a negedge monitor pops the scoreboard whenever a head is consumed.
module tb_llc_input_queues;
  import llc_input_queues_pkg::*;
  localparam int DEPTH = 2;
  typedef logic [127:0] bits_t;
  logic clk = 1'b0, rst = 1'b0;
  logic [3:0] v = '0, g = '0;
  logic ss = 1'b0, cs = 1'b0;
  llc_req_in_t dr;
  llc_rsp_in_t drs;
  llc_dma_req_in_t dd;
  logic dt;
  logic [3:0] rdy, vi;
  llc_req_in_t h_req, st_out, s;
  llc_rsp_in_t h_rsp;
  llc_dma_req_in_t h_dma;
  logic h_rst, st_valid, uf_out;
  llc_set_t st_set;
  llc_tag_t st_tag;
  bits_t x[3], h[3];
  bits_t mq[3][$];
  bits_t sb[3][$];
  logic tv = 1'b0, td = 1'b0, stv = 1'b0, st_known = 1'b0, uf = 1'b0;
  bits_t st;
  int n_chk = 0, n_fail = 0;
  bit mon_on = 1'b0;
  assign x[0] = bits_t'(dr);
  assign x[1] = bits_t'(drs);
  assign x[2] = bits_t'(dd);
  assign h[0] = bits_t'(h_req);
  assign h[1] = bits_t'(h_rsp);
  assign h[2] = bits_t'(h_dma);
  always #5 clk = ~clk;

  llc_input_queues #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .llc_req_in_valid(v[0]), .llc_req_in_ready(rdy[0]), .llc_req_in_data(dr),
    .llc_rsp_in_valid(v[1]), .llc_rsp_in_ready(rdy[1]), .llc_rsp_in_data(drs),
    .llc_dma_req_in_valid(v[2]), .llc_dma_req_in_ready(rdy[2]), .llc_dma_req_in_data(dd),
    .llc_rst_tb_valid(v[3]), .llc_rst_tb_ready(rdy[3]), .llc_rst_tb_data(dt),
    .get_req(g[0]), .get_rsp(g[1]), .get_dma_req(g[2]), .get_rst_tb(g[3]),
    .llc_req_in_valid_int(vi[0]), .llc_rsp_in_valid_int(vi[1]),
    .llc_dma_req_in_valid_int(vi[2]), .llc_rst_tb_valid_int(vi[3]),
    .req_in_head(h_req), .rsp_in_head(h_rsp), .dma_req_in_head(h_dma), .rst_tb_head(h_rst),
    .set_req_in_stalled(ss), .clr_req_in_stalled_valid(cs),
    .req_in_stalled_valid(st_valid), .req_in_stalled(st_out),
    .req_in_stalled_set(st_set), .req_in_stalled_tag(st_tag),
    .underflow_err(uf_out));

  task automatic chk(input string n, input bits_t a, input bits_t e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  task automatic rnd();
    bits_t r;
    r = {$urandom, $urandom, $urandom, $urandom};
    dr = r[$bits(llc_req_in_t)-1:0];
    r = {$urandom, $urandom, $urandom, $urandom};
    drs = r[$bits(llc_rsp_in_t)-1:0];
    r = {$urandom, $urandom, $urandom, $urandom};
    dd = r[$bits(llc_dma_req_in_t)-1:0];
    dt = 1'($urandom);
  endtask

  task automatic idle();
    v = '0;
    g = '0;
    ss = 1'b0;
    cs = 1'b0;
  endtask

  // Reference behaviour: each channel is an ordered list bounded at DEPTH.
  task automatic step();
    int n;
    @(posedge clk);
    if (!rst) begin
      for (int c = 0; c < 3; c++) begin
        mq[c].delete();
        sb[c].delete();
      end
      tv = 1'b0;
      stv = 1'b0;
      uf = 1'b0;
    end else begin
      if (ss) begin
        stv = 1'b1;
        st_known = mq[0].size() != 0;
        if (st_known) st = mq[0][0];
      end else if (cs) stv = 1'b0;
      for (int c = 0; c < 3; c++) begin
        n = mq[c].size();
        if (g[c]) begin
          if (n == 0) uf = 1'b1;
          else void'(mq[c].pop_front());
        end
        if (v[c] && n != DEPTH) begin
          mq[c].push_back(x[c]);
          sb[c].push_back(x[c]);
        end
      end
      if (g[3] && tv) tv = 1'b0;
      else if (v[3] && !tv) begin
        tv = 1'b1;
        td = dt;
      end
    end
    #1;
  endtask

  always @(negedge clk) if (mon_on) begin
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("valid_int%0d", c), bits_t'(vi[c]), bits_t'(mq[c].size() != 0));
      chk($sformatf("ready%0d", c), bits_t'(rdy[c]), bits_t'(mq[c].size() != DEPTH));
      if (rst && g[c] && vi[c]) begin
        if (sb[c].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL head%0d: got %0h expected none queued", c, h[c]);
        end else chk($sformatf("head%0d", c), h[c], sb[c].pop_front());
      end
    end
    chk("rst_tb_valid", bits_t'(vi[3]), bits_t'(tv));
    chk("rst_tb_ready", bits_t'(rdy[3]), bits_t'(!tv));
    if (tv) chk("rst_tb_head", bits_t'(h_rst), bits_t'(td));
    chk("underflow", bits_t'(uf_out), bits_t'(uf));
    chk("stalled_valid", bits_t'(st_valid), bits_t'(stv));
    if (stv && st_known) begin
      s = st[$bits(llc_req_in_t)-1:0];
      chk("stalled", bits_t'(st_out), st);
      chk("stalled_set", bits_t'(st_set), bits_t'(s.addr % (1 << LLC_SET_BITS)));
      chk("stalled_tag", bits_t'(st_tag), bits_t'(s.addr >> LLC_SET_BITS));
    end
  end

  initial begin
    rnd();
    idle();
    step();
    step();
    rst = 1'b1;
    mon_on = 1'b1;
    step();
    // fill req to DEPTH, then a refused third push
    v[0] = 1'b1;
    repeat (3) begin
      rnd();
      step();
    end
    chk("full_ready", bits_t'(rdy[0]), '0);
    g[0] = 1'b1;
    rnd();
    step();
    g[0] = 1'b0;
    step();
    v[0] = 1'b0;
    g[0] = 1'b1;
    step();
    step();
    idle();
    // stream through rsp to wrap pointers
    v[1] = 1'b1;
    rnd();
    step();
    g[1] = 1'b1;
    repeat (8) begin
      rnd();
      step();
    end
    v[1] = 1'b0;
    step();
    idle();
    // stalled capture with known set/tag
    rnd();
    dr.addr = line_addr_t'((32'h2A << LLC_SET_BITS) | 32'h1F);
    v[0] = 1'b1;
    step();
    idle();
    ss = 1'b1;
    step();
    chk("dir_set", bits_t'(st_set), 128'h1F);
    chk("dir_tag", bits_t'(st_tag), 128'h2A);
    chk("dir_req_kept", bits_t'(vi[0]), 128'h1);
    cs = 1'b1;
    step();
    chk("set_wins", bits_t'(st_valid), 128'h1);
    ss = 1'b0;
    step();
    idle();
    g[0] = 1'b1;
    step();
    idle();
    // underflow on empty dma
    g[2] = 1'b1;
    step();
    idle();
    step();
    chk("dir_underflow", bits_t'(uf_out), 128'h1);
    // mid-operation reset with queues holding 2/1/2
    rnd();
    v = 4'b1111;
    step();
    rnd();
    v = 4'b0101;
    ss = 1'b1;
    step();
    rst = 1'b0;
    v = 4'b1111;
    g = 4'b0111;
    step();
    rst = 1'b1;
    idle();
    step();
    chk("rst_valid_int", bits_t'(vi), '0);
    chk("rst_ready", bits_t'(rdy), 128'hF);
    chk("rst_stalled", bits_t'(st_valid), '0);
    chk("rst_underflow", bits_t'(uf_out), '0);
    repeat (3000) begin
      rnd();
      v = 4'($urandom);
      g[2:0] = 3'($urandom) & 3'($urandom);
      g[3] = tv & 1'($urandom);
      ss = $urandom_range(0, 9) == 0;
      cs = $urandom_range(0, 7) == 0;
      rst = $urandom_range(0, 199) != 0;
      step();
    end
    rst = 1'b1;
    idle();
    step();
    step();
    mon_on = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/llc_input_queues.md
LLC_INPUT_QUEUES -- requirements
Module: llc_input_queues

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning entries per request/response/DMA queue (power of 2, 2..8).
REQ-002 SHALL have ports clk (in, 1, rising-edge clock) and rst (in, 1, synchronous active-low reset).
REQ-003 SHALL have llc_req_in_valid/llc_req_in_ready/llc_req_in_data (in/out/in, 1/1/llc_req_in_t): CPU request channel from NoC.
REQ-004 SHALL have llc_rsp_in_valid/llc_rsp_in_ready/llc_rsp_in_data (in/out/in, 1/1/llc_rsp_in_t): coherence response channel.
REQ-005 SHALL have llc_dma_req_in_valid/llc_dma_req_in_ready/llc_dma_req_in_data (in/out/in, 1/1/llc_dma_req_in_t): DMA request channel.
REQ-006 SHALL have llc_rst_tb_valid/llc_rst_tb_ready/llc_rst_tb_data (in/out/in, 1/1/1): testbench reset/flush request.
REQ-007 SHALL have get_req, get_rsp, get_dma_req, get_rst_tb (in, 1 each): decoder pop strobes.
REQ-008 SHALL have llc_req_in_valid_int, llc_rsp_in_valid_int, llc_dma_req_in_valid_int, llc_rst_tb_valid_int (out, 1 each): queue heads valid.
REQ-009 SHALL have req_in_head, rsp_in_head, dma_req_in_head (out, packet types) and rst_tb_head (out, 1): head contents.
REQ-010 SHALL have set_req_in_stalled, clr_req_in_stalled_valid (in, 1 each): stalled-request capture/clear controls.
REQ-011 SHALL have req_in_stalled_valid (out, 1), req_in_stalled (out, llc_req_in_t), req_in_stalled_set (out, llc_set_t), req_in_stalled_tag (out, llc_tag_t).
REQ-012 SHALL have underflow_err (out, 1): sticky pop-on-empty flag.

Function
REQ-013 Each of req/rsp/dma queues SHALL be a DEPTH-entry circular FIFO: wr_ptr, rd_ptr, count of clog2(DEPTH)+1 bits; pointers wrap DEPTH-1 -> 0.
REQ-014 Push SHALL occur on valid && ready; ready SHALL be registered-state-derived (count != DEPTH), with no combinational path from get_* or valid.
REQ-015 Full queue with same-cycle pop SHALL keep ready=0 that cycle; count becomes DEPTH-1, ready=1 next cycle.
REQ-016 Simultaneous push and pop on non-empty, non-full queue SHALL leave count unchanged and advance both pointers.
REQ-017 Push-to-visible latency SHALL be 1 cycle: data accepted at edge N drives *_valid_int=1 and head after edge N.
REQ-018 *_valid_int SHALL equal (count != 0); head SHALL be entry at rd_ptr, unregistered mux from storage.
REQ-019 Pop on empty queue SHALL not change pointers/count and SHALL set underflow_err, held until reset.
REQ-020 rst_tb SHALL be a 1-entry register: ready = !valid_int; get_rst_tb clears; same-cycle push blocked while full.
REQ-021 set_req_in_stalled SHALL load req_in_stalled from req_in_head, set req_in_stalled_valid=1, and SHALL NOT pop the req queue.
REQ-022 req_in_stalled_set/tag SHALL be the set and tag fields of req_in_stalled.addr (set = low LLC_SET_BITS, tag = remaining upper bits of line address).
REQ-023 set_req_in_stalled and clr_req_in_stalled_valid in same cycle SHALL result in valid=1 with new data (set wins).
REQ-024 set_req_in_stalled while already valid SHALL overwrite contents.
REQ-025 Queues SHALL be independent; activity on one channel SHALL never stall another.

Reset
REQ-026 On rst=0 at a clock edge: all counts, pointers, rst_tb valid, req_in_stalled_valid, underflow_err SHALL clear to 0; all *_valid_int=0; ready outputs=1 from the first cycle after reset.
REQ-027 Reset mid-operation SHALL discard all queued entries; storage contents need not be cleared; heads are don't-care while valid_int=0.
REQ-028 Inputs during reset cycles SHALL be ignored (no push, no pop, no error).

Structure
REQ-029 llc_req_in_t, llc_rsp_in_t, llc_dma_req_in_t, llc_set_t, llc_tag_t, line_addr_t, LLC_SET_BITS SHALL come from the shared cache types/consts package.
REQ-030 One parameterized sub-module llc_input_fifo (type parameter, DEPTH) SHALL be instantiated three times; rst_tb and stalled-request registers are inline.

Verification
REQ-031 DEPTH=2: push req A, B on consecutive cycles, no pops -> valid_int=1 after first edge, head=A, ready=0 after second edge; third push refused.
REQ-032 Full req queue, get_req=1 with valid=1 pending -> pop A, head=B, ready=0 that cycle, push accepted next cycle.
REQ-033 8 push/pop pairs through rsp queue -> pointers wrap, count constant, output order matches input order.
REQ-034 Head addr set=0x1F, tag=0x2A; set_req_in_stalled=1 -> next cycle stalled_valid=1, set=0x1F, tag=0x2A, req count unchanged; set+clr same cycle -> valid stays 1.
REQ-035 get_dma_req on empty -> count stays 0, underflow_err=1 until rst=0.
REQ-036 Queues holding 2/1/2 entries, rst=0 one cycle -> all valid_int=0, all ready=1, stalled_valid=0 next cycle.
